control_unit: RTL and testbench



---
 rtl/control_unit.sv | 199 +++++++++++++++++++
 tb/tb_control_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Brief    : Hardwired Moore controller sequencing fetch/decode/execute for datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit #(
    parameter logic [4:0] OP_LD   = 5'b00000,
    parameter logic [4:0] OP_LDI  = 5'b00001,
    parameter logic [4:0] OP_ST   = 5'b00010,
    parameter logic [4:0] OP_ADD  = 5'b00011,
    parameter logic [4:0] OP_SUB  = 5'b00100,
    parameter logic [4:0] OP_AND  = 5'b00101,
    parameter logic [4:0] OP_OR   = 5'b00110,
    parameter logic [4:0] OP_ADDI = 5'b01100,
    parameter logic [4:0] OP_BR   = 5'b10010,
    parameter logic [4:0] OP_IN   = 5'b10110,
    parameter logic [4:0] OP_OUT  = 5'b10111,
    parameter logic [4:0] OP_NOP  = 5'b11010,
    parameter logic [4:0] OP_HALT = 5'b11011
) (
    input  logic       Clock,
    input  logic       Clear,
    input  logic [4:0] opcode,
    input  logic       CON_FF,
    input  logic       Stop,
    output logic       PCout, PCin, IncPC,
    output logic       MARin, MDRin, MDRout, Read, RAMin,
    output logic       IRin, Yin, ZLowIn, ZLowout, Cout, CONin,
    output logic       GRA, GRB, GRC, BAout, Rin, Rout,
    output logic       InPortOut, OutPortIn,
    output logic       ZHighIn, ZHighout, HIin, HIout, LOin, LOout, InPortIn,
    output logic       Run
);

    typedef enum logic [4:0] {
        ST_RST, ST_T0, ST_T1, ST_T2,
        ST_ALU_T3, ST_ALU_T4, ST_ALU_T5,
        ST_ADDI_T3, ST_ADDI_T4, ST_ADDI_T5,
        ST_LDI_T3, ST_LDI_T4, ST_LDI_T5,
        ST_LD_T3, ST_LD_T4, ST_LD_T5, ST_LD_T6, ST_LD_T7,
        ST_ST_T3, ST_ST_T4, ST_ST_T5, ST_ST_T6, ST_ST_T7,
        ST_BR_T3, ST_BR_T4, ST_BR_T5, ST_BR_T6,
        ST_IN_T3, ST_OUT_T3, ST_NOP_T3, ST_HLT_T3, ST_HALT
    } state_t;

    localparam logic [22:0] c_PCOUT     = 23'd1 << 0;
    localparam logic [22:0] c_PCIN      = 23'd1 << 1;
    localparam logic [22:0] c_INCPC     = 23'd1 << 2;
    localparam logic [22:0] c_MARIN     = 23'd1 << 3;
    localparam logic [22:0] c_MDRIN     = 23'd1 << 4;
    localparam logic [22:0] c_MDROUT    = 23'd1 << 5;
    localparam logic [22:0] c_READ      = 23'd1 << 6;
    localparam logic [22:0] c_RAMIN     = 23'd1 << 7;
    localparam logic [22:0] c_IRIN      = 23'd1 << 8;
    localparam logic [22:0] c_YIN       = 23'd1 << 9;
    localparam logic [22:0] c_ZLOWIN    = 23'd1 << 10;
    localparam logic [22:0] c_ZLOWOUT   = 23'd1 << 11;
    localparam logic [22:0] c_COUT      = 23'd1 << 12;
    localparam logic [22:0] c_CONIN     = 23'd1 << 13;
    localparam logic [22:0] c_GRA       = 23'd1 << 14;
    localparam logic [22:0] c_GRB       = 23'd1 << 15;
    localparam logic [22:0] c_GRC       = 23'd1 << 16;
    localparam logic [22:0] c_BAOUT     = 23'd1 << 17;
    localparam logic [22:0] c_RIN       = 23'd1 << 18;
    localparam logic [22:0] c_ROUT      = 23'd1 << 19;
    localparam logic [22:0] c_INPORTOUT = 23'd1 << 20;
    localparam logic [22:0] c_OUTPORTIN = 23'd1 << 21;
    localparam logic [22:0] c_RUN       = 23'd1 << 22;

    state_t      r_state;
    state_t      w_next;
    logic [22:0] r_ctrl;

    // Strobes are registered from the next state so they line up with r_state.
    function automatic logic [22:0] f_decode(input state_t s, input logic con_ff);
        logic [22:0] v;
        v = '0;
        case (s)
            ST_T0:                             v = c_PCOUT | c_MARIN | c_INCPC | c_ZLOWIN;
            ST_T1:                             v = c_ZLOWOUT | c_PCIN | c_READ | c_MDRIN;
            ST_T2:                             v = c_MDROUT | c_IRIN;
            ST_ALU_T3, ST_ADDI_T3:             v = c_GRB | c_ROUT | c_YIN;
            ST_ALU_T4:                         v = c_GRC | c_ROUT | c_ZLOWIN;
            ST_LDI_T3, ST_LD_T3, ST_ST_T3:     v = c_GRB | c_BAOUT | c_YIN;
            ST_ADDI_T4, ST_LDI_T4, ST_LD_T4,
            ST_ST_T4, ST_BR_T5:                v = c_COUT | c_ZLOWIN;
            ST_ALU_T5, ST_ADDI_T5, ST_LDI_T5:  v = c_ZLOWOUT | c_GRA | c_RIN;
            ST_LD_T5, ST_ST_T5:                v = c_ZLOWOUT | c_MARIN;
            ST_LD_T6:                          v = c_READ | c_MDRIN;
            ST_LD_T7:                          v = c_MDROUT | c_GRA | c_RIN;
            ST_ST_T6:                          v = c_GRA | c_ROUT | c_MDRIN;
            ST_ST_T7:                          v = c_RAMIN;
            ST_BR_T3:                          v = c_GRA | c_ROUT | c_CONIN;
            ST_BR_T4:                          v = c_PCOUT | c_YIN;
            ST_BR_T6:                          v = c_ZLOWOUT | (con_ff ? c_PCIN : 23'd0);
            ST_IN_T3:                          v = c_INPORTOUT | c_GRA | c_RIN;
            ST_OUT_T3:                         v = c_GRA | c_ROUT | c_OUTPORTIN;
            default:                           v = '0;
        endcase
        if (s != ST_RST && s != ST_HALT) v = v | c_RUN;
        return v;
    endfunction

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST:     w_next = ST_T0;
            ST_T0:      w_next = ST_T1;
            ST_T1:      w_next = ST_T2;
            ST_T2: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: w_next = ST_ALU_T3;
                    OP_ADDI: w_next = ST_ADDI_T3;
                    OP_LDI:  w_next = ST_LDI_T3;
                    OP_LD:   w_next = ST_LD_T3;
                    OP_ST:   w_next = ST_ST_T3;
                    OP_BR:   w_next = ST_BR_T3;
                    OP_IN:   w_next = ST_IN_T3;
                    OP_OUT:  w_next = ST_OUT_T3;
                    OP_HALT: w_next = ST_HLT_T3;
                    OP_NOP:  w_next = ST_NOP_T3;
                    default: w_next = ST_NOP_T3;
                endcase
            end
            ST_ALU_T3:  w_next = ST_ALU_T4;
            ST_ALU_T4:  w_next = ST_ALU_T5;
            ST_ADDI_T3: w_next = ST_ADDI_T4;
            ST_ADDI_T4: w_next = ST_ADDI_T5;
            ST_LDI_T3:  w_next = ST_LDI_T4;
            ST_LDI_T4:  w_next = ST_LDI_T5;
            ST_LD_T3:   w_next = ST_LD_T4;
            ST_LD_T4:   w_next = ST_LD_T5;
            ST_LD_T5:   w_next = ST_LD_T6;
            ST_LD_T6:   w_next = ST_LD_T7;
            ST_ST_T3:   w_next = ST_ST_T4;
            ST_ST_T4:   w_next = ST_ST_T5;
            ST_ST_T5:   w_next = ST_ST_T6;
            ST_ST_T6:   w_next = ST_ST_T7;
            ST_BR_T3:   w_next = ST_BR_T4;
            ST_BR_T4:   w_next = ST_BR_T5;
            ST_BR_T5:   w_next = ST_BR_T6;
            ST_ALU_T5, ST_ADDI_T5, ST_LDI_T5, ST_LD_T7, ST_ST_T7,
            ST_BR_T6, ST_IN_T3, ST_OUT_T3, ST_NOP_T3:
                        w_next = ST_T0;
            ST_HLT_T3:  w_next = ST_HALT;
            ST_HALT:    w_next = ST_HALT;
            default:    w_next = ST_RST;
        endcase
        // Stop only acts at an instruction boundary, so the current instruction finishes.
        if (w_next == ST_T0 && Stop) w_next = ST_HALT;
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state <= ST_RST;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_decode(w_next, CON_FF);
        end
    end

    assign PCout     = r_ctrl[0];
    assign PCin      = r_ctrl[1];
    assign IncPC     = r_ctrl[2];
    assign MARin     = r_ctrl[3];
    assign MDRin     = r_ctrl[4];
    assign MDRout    = r_ctrl[5];
    assign Read      = r_ctrl[6];
    assign RAMin     = r_ctrl[7];
    assign IRin      = r_ctrl[8];
    assign Yin       = r_ctrl[9];
    assign ZLowIn    = r_ctrl[10];
    assign ZLowout   = r_ctrl[11];
    assign Cout      = r_ctrl[12];
    assign CONin     = r_ctrl[13];
    assign GRA       = r_ctrl[14];
    assign GRB       = r_ctrl[15];
    assign GRC       = r_ctrl[16];
    assign BAout     = r_ctrl[17];
    assign Rin       = r_ctrl[18];
    assign Rout      = r_ctrl[19];
    assign InPortOut = r_ctrl[20];
    assign OutPortIn = r_ctrl[21];
    assign Run       = r_ctrl[22];

    assign ZHighIn   = 1'b0;
    assign ZHighout  = 1'b0;
    assign HIin      = 1'b0;
    assign HIout     = 1'b0;
    assign LOin      = 1'b0;
    assign LOout     = 1'b0;
    assign InPortIn  = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Brief    : Scoreboard bench for control_unit strobe sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    localparam logic [29:0] B_PCOUT     = 30'd1 << 0;
    localparam logic [29:0] B_PCIN      = 30'd1 << 1;
    localparam logic [29:0] B_INCPC     = 30'd1 << 2;
    localparam logic [29:0] B_MARIN     = 30'd1 << 3;
    localparam logic [29:0] B_MDRIN     = 30'd1 << 4;
    localparam logic [29:0] B_MDROUT    = 30'd1 << 5;
    localparam logic [29:0] B_READ      = 30'd1 << 6;
    localparam logic [29:0] B_RAMIN     = 30'd1 << 7;
    localparam logic [29:0] B_IRIN      = 30'd1 << 8;
    localparam logic [29:0] B_YIN       = 30'd1 << 9;
    localparam logic [29:0] B_ZLOWIN    = 30'd1 << 10;
    localparam logic [29:0] B_ZLOWOUT   = 30'd1 << 11;
    localparam logic [29:0] B_COUT      = 30'd1 << 12;
    localparam logic [29:0] B_CONIN     = 30'd1 << 13;
    localparam logic [29:0] B_GRA       = 30'd1 << 14;
    localparam logic [29:0] B_GRB       = 30'd1 << 15;
    localparam logic [29:0] B_GRC       = 30'd1 << 16;
    localparam logic [29:0] B_BAOUT     = 30'd1 << 17;
    localparam logic [29:0] B_RIN       = 30'd1 << 18;
    localparam logic [29:0] B_ROUT      = 30'd1 << 19;
    localparam logic [29:0] B_INPORTOUT = 30'd1 << 20;
    localparam logic [29:0] B_OUTPORTIN = 30'd1 << 21;
    localparam logic [29:0] B_RUN       = 30'd1 << 22;

    localparam logic [4:0] C_LD = 5'b00000, C_LDI = 5'b00001, C_ST = 5'b00010;
    localparam logic [4:0] C_ADD = 5'b00011, C_SUB = 5'b00100, C_AND = 5'b00101, C_OR = 5'b00110;
    localparam logic [4:0] C_ADDI = 5'b01100, C_BR = 5'b10010, C_IN = 5'b10110, C_OUT = 5'b10111;
    localparam logic [4:0] C_NOP = 5'b11010, C_HALT = 5'b11011, C_UNDEF = 5'b11111;

    logic       Clock, Clear, CON_FF, Stop;
    logic [4:0] opcode;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, RAMin;
    logic IRin, Yin, ZLowIn, ZLowout, Cout, CONin;
    logic GRA, GRB, GRC, BAout, Rin, Rout, InPortOut, OutPortIn;
    logic ZHighIn, ZHighout, HIin, HIout, LOin, LOout, InPortIn, Run;
    logic [29:0] obs;

    logic [29:0] q[$];
    int compared;
    int mismatched;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .opcode(opcode), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .RAMin(RAMin),
        .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZLowout(ZLowout), .Cout(Cout), .CONin(CONin),
        .GRA(GRA), .GRB(GRB), .GRC(GRC), .BAout(BAout), .Rin(Rin), .Rout(Rout),
        .InPortOut(InPortOut), .OutPortIn(OutPortIn),
        .ZHighIn(ZHighIn), .ZHighout(ZHighout), .HIin(HIin), .HIout(HIout),
        .LOin(LOin), .LOout(LOout), .InPortIn(InPortIn), .Run(Run)
    );

    assign obs = {ZHighIn, ZHighout, HIin, HIout, LOin, LOout, InPortIn, Run,
                  OutPortIn, InPortOut, Rout, Rin, BAout, GRC, GRB, GRA, CONin, Cout,
                  ZLowout, ZLowIn, Yin, IRin, RAMin, Read, MDRout, MDRin, MARin,
                  IncPC, PCin, PCout};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference strobe sequence for one instruction, fetch included.
    task automatic push_instr(input logic [4:0] op, input logic con);
        q.push_back(B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN);
        q.push_back(B_RUN | B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN);
        q.push_back(B_RUN | B_MDROUT | B_IRIN);
        case (op)
            C_ADD, C_SUB, C_AND, C_OR: begin
                q.push_back(B_RUN | B_GRB | B_ROUT | B_YIN);
                q.push_back(B_RUN | B_GRC | B_ROUT | B_ZLOWIN);
                q.push_back(B_RUN | B_ZLOWOUT | B_GRA | B_RIN);
            end
            C_ADDI, C_LDI: begin
                q.push_back(B_RUN | B_GRB | (op == C_LDI ? B_BAOUT : B_ROUT) | B_YIN);
                q.push_back(B_RUN | B_COUT | B_ZLOWIN);
                q.push_back(B_RUN | B_ZLOWOUT | B_GRA | B_RIN);
            end
            C_LD, C_ST: begin
                q.push_back(B_RUN | B_GRB | B_BAOUT | B_YIN);
                q.push_back(B_RUN | B_COUT | B_ZLOWIN);
                q.push_back(B_RUN | B_ZLOWOUT | B_MARIN);
                if (op == C_LD) begin
                    q.push_back(B_RUN | B_READ | B_MDRIN);
                    q.push_back(B_RUN | B_MDROUT | B_GRA | B_RIN);
                end else begin
                    q.push_back(B_RUN | B_GRA | B_ROUT | B_MDRIN);
                    q.push_back(B_RUN | B_RAMIN);
                end
            end
            C_BR: begin
                q.push_back(B_RUN | B_GRA | B_ROUT | B_CONIN);
                q.push_back(B_RUN | B_PCOUT | B_YIN);
                q.push_back(B_RUN | B_COUT | B_ZLOWIN);
                q.push_back(B_RUN | B_ZLOWOUT | (con ? B_PCIN : 30'd0));
            end
            C_IN:    q.push_back(B_RUN | B_INPORTOUT | B_GRA | B_RIN);
            C_OUT:   q.push_back(B_RUN | B_GRA | B_ROUT | B_OUTPORTIN);
            default: q.push_back(B_RUN);
        endcase
    endtask

    task automatic test_reset();
        logic [29:0] e;
        Clear = 1'b1;
        repeat (2) q.push_back(30'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge Clock); #1;
            e = q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL reset[%0d]: got %h expected %h", k, obs, e);
            end
        end
        Clear = 1'b0;
    endtask

    task automatic test_alu();
        logic [29:0] e;
        logic [4:0] ops [6];
        ops = '{C_ADD, C_SUB, C_AND, C_OR, C_ADDI, C_LDI};
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i];
            push_instr(ops[i], 1'b0);
            for (int k = 0; k < 6; k++) begin
                @(posedge Clock); #1;
                compared++;
                if (q.size() == 0) begin
                    mismatched++;
                    $display("FAIL alu op=%b cyc%0d: got %h expected nothing", ops[i], k, obs);
                end else begin
                    e = q.pop_front();
                    if (obs !== e) begin
                        mismatched++;
                        $display("FAIL alu op=%b cyc%0d: got %h expected %h", ops[i], k, obs, e);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [29:0] e;
        logic [4:0] ops [2];
        ops = '{C_LD, C_ST};
        for (int i = 0; i < 2; i++) begin
            opcode = ops[i];
            push_instr(ops[i], 1'b0);
            for (int k = 0; k < 8; k++) begin
                @(posedge Clock); #1;
                e = q.pop_front();
                compared++;
                if (obs !== e) begin
                    mismatched++;
                    $display("FAIL ldst op=%b cyc%0d: got %h expected %h", ops[i], k, obs, e);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [29:0] e;
        for (int i = 0; i < 2; i++) begin
            opcode = C_BR;
            CON_FF = (i == 0);
            push_instr(C_BR, CON_FF);
            for (int k = 0; k < 7; k++) begin
                @(posedge Clock); #1;
                e = q.pop_front();
                compared++;
                if (obs !== e) begin
                    mismatched++;
                    $display("FAIL br con=%0d cyc%0d: got %h expected %h", CON_FF, k, obs, e);
                end
            end
        end
        CON_FF = 1'b0;
    endtask

    task automatic test_io();
        logic [29:0] e;
        logic [4:0] ops [4];
        ops = '{C_IN, C_OUT, C_NOP, C_UNDEF};
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            push_instr(ops[i], 1'b0);
            for (int k = 0; k < 4; k++) begin
                @(posedge Clock); #1;
                e = q.pop_front();
                compared++;
                if (obs !== e) begin
                    mismatched++;
                    $display("FAIL io op=%b cyc%0d: got %h expected %h", ops[i], k, obs, e);
                end
            end
        end
    endtask

    task automatic test_stop();
        logic [29:0] e;
        opcode = C_ADD;
        push_instr(C_ADD, 1'b0);
        repeat (20) q.push_back(30'd0);
        q.push_back(30'd0);
        for (int k = 0; k < 27; k++) begin
            if (k == 26) begin
                Stop  = 1'b0;
                Clear = 1'b1;
            end
            @(posedge Clock); #1;
            e = q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL stop cyc%0d: got %h expected %h", k, obs, e);
            end
            if (k == 4) Stop = 1'b1;
        end
        Clear = 1'b0;
    endtask

    task automatic test_halt();
        logic [29:0] e;
        opcode = C_HALT;
        push_instr(C_HALT, 1'b0);
        repeat (6) q.push_back(30'd0);
        q.push_back(30'd0);
        for (int k = 0; k < 11; k++) begin
            if (k == 10) Clear = 1'b1;
            @(posedge Clock); #1;
            e = q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL halt cyc%0d: got %h expected %h", k, obs, e);
            end
        end
        Clear = 1'b0;
        // ld aborted by Clear while in its T6, then a clean nop afterwards.
        opcode = C_LD;
        push_instr(C_LD, 1'b0);
        void'(q.pop_back());
        q.push_back(30'd0);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) Clear = 1'b1;
            @(posedge Clock); #1;
            e = q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL abort cyc%0d: got %h expected %h", k, obs, e);
            end
        end
        Clear = 1'b0;
        opcode = C_NOP;
        push_instr(C_NOP, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge Clock); #1;
            e = q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL recover cyc%0d: got %h expected %h", k, obs, e);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        Clear      = 1'b1;
        Stop       = 1'b0;
        CON_FF     = 1'b0;
        opcode     = C_NOP;
        test_reset();
        test_alu();
        test_back_to_back();
        test_branch();
        test_io();
        test_stop();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
